// File: rtl/divisor_secuencial_pkg.sv
// rtl/divisor_secuencial_pkg.sv - shared state, flag index and constant definitions for the divider
package divisor_secuencial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Sliced down to the operand width at the point of use.
    localparam logic [31:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/divisor_secuencial_resta.sv
// rtl/divisor_secuencial_resta.sv - n-bit subtractor c = a - b with N/Z/C/V flags
import divisor_secuencial_pkg::*;

module resta #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] c,
    output logic [3:0]   banderas
);

    logic [n:0] sum;

    // Two's-complement add of ~b + 1; the carry out means "no borrow".
    assign sum = {1'b0, a} + {1'b0, ~b} + {{n{1'b0}}, 1'b1};
    assign c   = sum[n-1:0];

    always_comb begin
        banderas         = '0;
        banderas[FLAG_N] = sum[n-1];
        banderas[FLAG_Z] = (sum[n-1:0] == '0);
        banderas[FLAG_C] = sum[n];
        banderas[FLAG_V] = (a[n-1] != b[n-1]) && (sum[n-1] != a[n-1]);
    end

endmodule

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - multi-cycle unsigned restoring divider with start/done handshake
import divisor_secuencial_pkg::*;

module divisor_secuencial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic [3:0]   banderas
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    div_state_e    state_q, state_d;
    logic [N:0]    p_q, p_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [3:0]    flags_q, flags_d;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic [3:0]    sub_flags;
    logic          borrow;
    logic [N:0]    p_next;
    logic [N-1:0]  q_next;
    logic          unused_sub_flags;

    assign shifted = {p_q[N-1:0], q_q[N-1]};

    resta #(
        .n (N + 1)
    ) u_resta (
        .a        (shifted),
        .b        ({1'b0, d_q}),
        .c        (diff),
        .banderas (sub_flags)
    );

    // P stays below D, so the MSB of the N+1 bit difference is an exact borrow.
    assign borrow           = sub_flags[FLAG_N];
    assign unused_sub_flags = ^sub_flags[FLAG_Z:FLAG_V];
    assign p_next           = borrow ? shifted : diff;
    assign q_next           = {q_q[N-2:0], ~borrow};

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        d_d     = divisor;
                        p_d     = '0;
                        q_d     = dividend;
                        cnt_d   = CW'(N - 1);
                        state_d = ITER;
                    end else begin
                        quot_d          = DIV_ZERO_QUOT[N-1:0];
                        rem_d           = dividend;
                        flags_d         = '0;
                        flags_d[FLAG_V] = 1'b1;
                        state_d         = DONE;
                    end
                end
            end
            ITER: begin
                p_d = p_next;
                q_d = q_next;
                if (cnt_q == '0) begin
                    quot_d          = q_next;
                    rem_d           = p_next[N-1:0];
                    flags_d         = '0;
                    flags_d[FLAG_Z] = (q_next == '0);
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            flags_q <= flags_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign banderas  = flags_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - directed self-checking bench for divisor_secuencial
module tb_divisor_secuencial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic [3:0] banderas;

    int total = 0;
    int bad   = 0;

    divisor_secuencial #(
        .N (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .banderas  (banderas)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Drives start for one cycle from an IDLE negedge; returns one negedge after the accepting edge.
    task automatic do_start(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk(tag, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_res(input string tag, input logic [7:0] q, input logic [7:0] r,
                             input logic [3:0] f);
        chk({tag, "_quot"}, 32'(quotient), 32'(q));
        chk({tag, "_rem"}, 32'(remainder), 32'(r));
        chk({tag, "_flags"}, 32'(banderas), 32'(f));
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] q, input logic [7:0] r, input logic [3:0] f,
                          input int lat);
        do_start(a, b);
        wait_done({tag, "_lat"}, lat);
        check_res(tag, q, r, f);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        check_res("rst", 8'd0, 8'd0, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 4'b0000, 9);
        run_op("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 4'b0000, 9);
        run_op("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 4'b0000, 9);
        run_op("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 4'b0100, 9);
        run_op("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 4'b0100, 9);
        run_op("d42_0", 8'd42, 8'd0, 8'hFF, 8'd42, 4'b0001, 1);

        @(negedge clk);
        chk("held_quot", 32'(quotient), 32'hFF);
        chk("held_done", 32'(done), 32'd0);

        // A start pulse during ITER must be dropped, not queued.
        do_start(8'd200, 8'd3);
        repeat (3) @(negedge clk);
        dividend = 8'd10;
        divisor  = 8'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_lat", 5);
        check_res("ign", 8'd66, 8'd2, 4'b0000);
        run_op("b2b_10_2", 8'd10, 8'd2, 8'd5, 8'd0, 4'b0000, 9);
        @(negedge clk);
        chk("no_queued_busy", 32'(busy), 32'd0);

        do_start(8'd200, 8'd3);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        check_res("abort", 8'd0, 8'd0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 8'd100, 8'd7, 8'd14, 8'd2, 4'b0000, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Multi-cycle unsigned restoring divider controller for the CPU execute stage.
- Sequences one shared subtractor instance over N iterations with a start/done handshake.
- The result and flags feed the writeback mux.
- A divide instruction stalls the pipeline while busy is high.

Parameters:
- N, 8, operand, quotient and remainder width in bits (N >= 2)

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  N  unsigned dividend, captured when start is accepted
- divisor  input  N  unsigned divisor, captured when start is accepted
- busy  output  1  high from the cycle after start is accepted until DONE is left
- done  output  1  one-cycle pulse; result valid
- quotient  output  N  unsigned quotient; held until the next accepted start
- remainder  output  N  unsigned remainder; held until the next accepted start
- banderas  output  4  [3] N, [2] Z, [1] C, [0] V; same bit order as the subtractor flags

Behaviour:
- Clocking: one clock, clk.
- Reset: rst_n is asynchronous, active-low. All state clears immediately.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, banderas=0, iteration counter=0.
- States: IDLE, ITER, DONE.
- IDLE, start=1 with divisor!=0: latch operands. Set partial remainder P (N+1 bits) = 0, Q = dividend, counter = N-1. Next state ITER.
- IDLE, start=1 with divisor==0: next state DONE directly. Outputs: quotient = all ones, remainder = dividend, banderas = 4'b0001 (V marks divide-by-zero).
- ITER, each cycle:
  - S = {P[N-1:0], Q[N-1]}.
  - Subtract D = {1'b0, divisor} from S using the shared subtractor at width N+1.
  - Borrow = subtractor negative flag.
  - If borrow=0: P = difference[N:0]; Q = {Q[N-2:0], 1}.
  - Else: P = S; Q = {Q[N-2:0], 0}.
  - Decrement the counter. When the counter is 0, next state is DONE.
- DONE: quotient = Q, remainder = P[N-1:0], done=1 for exactly this cycle. Next state is IDLE unconditionally.
- Flags on normal completion:
  - N = 0
  - Z = (quotient==0)
  - C = 0
  - V = 0
- Latency: start sampled at edge t; done high during the cycle after edge t+N+1. Divide-by-zero: done after edge t+1.
- busy is high in ITER and DONE, low in IDLE. start is ignored while busy (no queueing).
- A new start in the IDLE cycle immediately after DONE is accepted, so back-to-back operations are allowed.
- Outputs update only on entry to DONE. They are stable in IDLE.
- Operands are registered at acceptance. Input changes during ITER have no effect.
- Reset asserted mid-ITER: abort. Return to reset values, done is not pulsed.
- Boundaries:
  - dividend < divisor: quotient=0, remainder=dividend, Z=1.
  - dividend=0: quotient=0, remainder=0, Z=1.
  - divisor=1: quotient=dividend, remainder=0.
  - The P width of N+1 bits guarantees no overflow for divisor up to 2^N-1.

Decomposition:
- Shared CPU package:
  - State enum typedef (IDLE, ITER, DONE).
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Divide-by-zero quotient constant (all ones).
- Sub-module: one instance of the existing subtractor "resta" with n=N+1.
  - Its banderas[3] is used as the borrow.
  - Its output c is the difference.
- Counter width is $clog2(N).

Test Plan:
- N=8, dividend=100, divisor=7, start one cycle -> busy next cycle; done pulse 9 cycles after start; quotient=14, remainder=2, banderas=4'b0000.
- dividend=255, divisor=1 -> quotient=255, remainder=0, banderas=0. Then dividend=255, divisor=255 -> quotient=1, remainder=0.
- dividend=5, divisor=9 -> quotient=0, remainder=5, banderas=4'b0100. Also dividend=0, divisor=3 -> quotient=0, remainder=0, Z=1.
- dividend=42, divisor=0 -> done 1 cycle after start; quotient=8'hFF, remainder=42, banderas=4'b0001; no ITER cycles observed.
- Start 200/3, then pulse start with 10/2 during ITER -> ignored; result quotient=66, remainder=2. Next start in the IDLE cycle after done is accepted and gives quotient=5, remainder=0.
- Start 200/3, assert rst_n=0 asynchronously mid-ITER (between edges) -> busy, done, quotient, remainder and banderas go to 0 immediately. After release, 100/7 completes correctly.
